// File: rtl/lac_pkg.sv
// Shared types and helpers for the logic-accessible-clock phase tracker family.
package lac_pkg;

  // Lock tracking states.
  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } lac_state_e;

  // Common fast/slow ratios used by existing instances.
  localparam int MULT_4X = 4;
  localparam int MULT_5X = 5;

  // Width of a counter spanning 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/lac_edge_sync.sv
// Samples a fabric clock as data and flags its rising edges.
// The rise flag is combinational off the last two flops so that the
// consumer acts on it at the very next fast-clock edge.
module lac_edge_sync #(
  parameter int SYNC_STAGES = 1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic din,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   s_s;
  logic                   s_d_r;

  // Sampling chain: din enters at stage 0 and shifts towards the top stage.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
    end
  end

  assign s_s = sync_r[SYNC_STAGES-1];

  // One-cycle delayed copy of the sampled level for edge detection.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s_d_r <= 1'b0;
    end else begin
      s_d_r <= s_s;
    end
  end

  assign rise = s_s & ~s_d_r;

endmodule

// File: rtl/lac_phase_tracker.sv
// Tracks the fast-clock phase inside each 40 MHz period of clock_lac,
// declares lock after a run of correctly spaced edges, and emits a
// phase-aligned strobe plus loss-of-lock reporting.
module lac_phase_tracker
  import lac_pkg::*;
#(
  parameter  int MULT         = MULT_4X,
  parameter  int STROBE_PHASE = 0,
  parameter  int LOCK_COUNT   = 8,
  parameter  int SYNC_STAGES  = 1,
  parameter  int LOL_W        = 8,
  localparam int CW           = cnt_width(MULT)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clock_lac,
  input  logic             lol_clear,
  output logic             strobe,
  output logic [CW-1:0]    phase,
  output logic             locked,
  output logic             lol_pulse,
  output logic [LOL_W-1:0] lol_count
);

  if (MULT < 2) begin : g_chk_mult
    $fatal(1, "lac_phase_tracker: MULT must be at least 2");
  end
  if (STROBE_PHASE >= MULT) begin : g_chk_phase
    $fatal(1, "lac_phase_tracker: STROBE_PHASE must be below MULT");
  end
  if (LOCK_COUNT < 1) begin : g_chk_lock
    $fatal(1, "lac_phase_tracker: LOCK_COUNT must be at least 1");
  end

  localparam logic [CW-1:0] PH_LAST   = CW'(MULT - 1);
  localparam logic [CW-1:0] STROBE_PH = CW'(STROBE_PHASE);
  localparam logic [7:0]    GOOD_LAST = 8'(LOCK_COUNT - 1);

  logic             rise_s;
  logic             good_s;
  logic             err_s;
  lac_state_e       state_r,    state_nxt_s;
  logic [7:0]       good_cnt_r, good_cnt_nxt_s;
  logic [CW-1:0]    ph_r,       ph_nxt_s;
  logic [LOL_W-1:0] lol_cnt_r,  lol_cnt_nxt_s;
  logic             lol_pulse_nxt_s;
  logic             locked_r;
  logic             strobe_r;
  logic             lol_pulse_r;

  lac_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .din     (clock_lac),
    .rise    (rise_s)
  );

  // Edge classification against the pre-update phase, then lock state transitions.
  always_comb begin
    state_nxt_s     = state_r;
    good_cnt_nxt_s  = good_cnt_r;
    lol_pulse_nxt_s = 1'b0;
    good_s = rise_s & (ph_r == PH_LAST);
    err_s  = (rise_s & (ph_r != PH_LAST)) | (~rise_s & (ph_r == PH_LAST));
    case (state_r)
      HUNT: begin
        if (rise_s) begin
          state_nxt_s    = CHECK;
          good_cnt_nxt_s = 8'd0;
        end else begin
          state_nxt_s = HUNT;
        end
      end
      CHECK: begin
        if (err_s) begin
          state_nxt_s = HUNT;
        end else if (good_s) begin
          if (good_cnt_r == GOOD_LAST) begin
            state_nxt_s = LOCKED;
          end else begin
            good_cnt_nxt_s = good_cnt_r + 8'd1;
          end
        end else begin
          state_nxt_s = CHECK;
        end
      end
      LOCKED: begin
        if (err_s) begin
          state_nxt_s     = HUNT;
          lol_pulse_nxt_s = 1'b1;
        end else begin
          state_nxt_s = LOCKED;
        end
      end
      default: begin
        state_nxt_s    = HUNT;
        good_cnt_nxt_s = 8'd0;
      end
    endcase
  end

  // Phase counter: restart on every detected edge, otherwise wrap at MULT-1.
  always_comb begin
    ph_nxt_s = ph_r;
    if (rise_s) begin
      ph_nxt_s = {CW{1'b0}};
    end else if (ph_r == PH_LAST) begin
      ph_nxt_s = {CW{1'b0}};
    end else begin
      ph_nxt_s = ph_r + CW'(1'b1);
    end
  end

  // Loss-of-lock counter: clear has priority over a simultaneous loss, count saturates.
  always_comb begin
    lol_cnt_nxt_s = lol_cnt_r;
    if (lol_clear) begin
      lol_cnt_nxt_s = {LOL_W{1'b0}};
    end else if (lol_pulse_nxt_s && (lol_cnt_r != {LOL_W{1'b1}})) begin
      lol_cnt_nxt_s = lol_cnt_r + LOL_W'(1'b1);
    end else begin
      lol_cnt_nxt_s = lol_cnt_r;
    end
  end

  // State, counters and outputs, all registered from next-state values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= HUNT;
      good_cnt_r  <= 8'd0;
      ph_r        <= {CW{1'b0}};
      lol_cnt_r   <= {LOL_W{1'b0}};
      locked_r    <= 1'b0;
      strobe_r    <= 1'b0;
      lol_pulse_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      good_cnt_r  <= good_cnt_nxt_s;
      ph_r        <= ph_nxt_s;
      lol_cnt_r   <= lol_cnt_nxt_s;
      locked_r    <= (state_nxt_s == LOCKED);
      strobe_r    <= (state_nxt_s == LOCKED) & (ph_nxt_s == STROBE_PH);
      lol_pulse_r <= lol_pulse_nxt_s;
    end
  end

  assign phase     = ph_r;
  assign locked    = locked_r;
  assign strobe    = strobe_r;
  assign lol_pulse = lol_pulse_r;
  assign lol_count = lol_cnt_r;

endmodule

// File: tb/tb_lac_phase_tracker.sv
// Bench for lac_phase_tracker: a 4x instance (2-bit loss counter) takes the
// directed disturbances, a 5x instance with strobe phase 3 runs a steady
// 3-high/2-low clock_lac alongside. A reference model predicts every output
// of both instances each cycle; predictions are queued at drive time and
// compared after the clock edge that produces them.
module tb_lac_phase_tracker;

  localparam int M_HUNT   = 0;
  localparam int M_CHECK  = 1;
  localparam int M_LOCKED = 2;

  typedef struct {
    bit s1;
    bit s2;
    int ph;
    int st;
    int good_cnt;
    int lol;
  } mdl_t;

  typedef struct {
    int phase;
    bit locked;
    bit strobe;
    bit pulse;
    int lol;
  } exp_t;

  typedef struct {
    exp_t a;
    exp_t b;
  } sb_item_t;

  logic       clock;
  logic       reset_n;
  logic       lac_a;
  logic       lac_b;
  logic       lol_clear;
  logic       strobe_a,    strobe_b;
  logic [1:0] phase_a;
  logic [2:0] phase_b;
  logic       locked_a,    locked_b;
  logic       lol_pulse_a, lol_pulse_b;
  logic [1:0] lol_count_a;
  logic [7:0] lol_count_b;

  int       vectors;
  int       miscompares;
  int       b_pos;
  mdl_t     ma;
  mdl_t     mb;
  sb_item_t sb_q[$];

  lac_phase_tracker #(
    .MULT(4), .STROBE_PHASE(0), .LOCK_COUNT(8), .SYNC_STAGES(1), .LOL_W(2)
  ) u_dut_a (
    .clock     (clock),
    .reset_n   (reset_n),
    .clock_lac (lac_a),
    .lol_clear (lol_clear),
    .strobe    (strobe_a),
    .phase     (phase_a),
    .locked    (locked_a),
    .lol_pulse (lol_pulse_a),
    .lol_count (lol_count_a)
  );

  lac_phase_tracker #(
    .MULT(5), .STROBE_PHASE(3), .LOCK_COUNT(8), .SYNC_STAGES(1), .LOL_W(8)
  ) u_dut_b (
    .clock     (clock),
    .reset_n   (reset_n),
    .clock_lac (lac_b),
    .lol_clear (lol_clear),
    .strobe    (strobe_b),
    .phase     (phase_b),
    .locked    (locked_b),
    .lol_pulse (lol_pulse_b),
    .lol_count (lol_count_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference model for one fast-clock edge; lac is the value sampled at this edge.
  function automatic void mstep(inout mdl_t m, output exp_t e, input bit lac, input bit clr,
                                input int mult, input int sp, input int lc, input int lolmax);
    bit rise;
    bit good;
    bit err;
    bit pulse;
    int nst;
    rise  = m.s1 & ~m.s2;
    good  = rise && (m.ph == mult - 1);
    err   = (rise && (m.ph != mult - 1)) || (!rise && (m.ph == mult - 1));
    pulse = 1'b0;
    nst   = m.st;
    if (m.st == M_HUNT) begin
      if (rise) begin
        nst = M_CHECK;
        m.good_cnt = 0;
      end
    end else if (m.st == M_CHECK) begin
      if (err) nst = M_HUNT;
      else if (good) begin
        if (m.good_cnt == lc - 1) nst = M_LOCKED;
        else m.good_cnt = m.good_cnt + 1;
      end
    end else begin
      if (err) begin
        nst   = M_HUNT;
        pulse = 1'b1;
      end
    end
    if (clr) m.lol = 0;
    else if (pulse && m.lol < lolmax) m.lol = m.lol + 1;
    m.ph = rise ? 0 : (m.ph + 1) % mult;
    m.st = nst;
    m.s2 = m.s1;
    m.s1 = lac;
    e.phase  = m.ph;
    e.locked = (nst == M_LOCKED);
    e.strobe = (nst == M_LOCKED) && (m.ph == sp);
    e.pulse  = pulse;
    e.lol    = m.lol;
  endfunction

  // Drive one cycle of stimulus for both instances and queue the predicted outputs.
  task automatic cycle(input bit la, input bit clr);
    sb_item_t it;
    bit       lb;
    lb    = (b_pos < 3);
    b_pos = (b_pos + 1) % 5;
    lac_a     = la;
    lac_b     = lb;
    lol_clear = clr;
    mstep(ma, it.a, la, clr, 4, 0, 8, 3);
    mstep(mb, it.b, lb, clr, 5, 3, 8, 255);
    sb_q.push_back(it);
    @(negedge clock);
  endtask

  // One clock_lac period for instance A; dip forces one low cycle, clr_idx pulses lol_clear.
  task automatic a_period(input int len, input int hi, input int dip, input int clr_idx);
    for (int i = 0; i < len; i++) begin
      cycle((i < hi) && (i != dip), (i == clr_idx));
    end
  endtask

  task automatic a_normal(input int n);
    for (int k = 0; k < n; k++) a_period(4, 2, -1, -1);
  endtask

  task automatic model_reset();
    ma = '{default: 0};
    mb = '{default: 0};
  endtask

  // Scoreboard consumer: compare queued predictions shortly after each active edge.
  always @(posedge clock) begin
    sb_item_t it;
    #2;
    if (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      chk("a_phase",     phase_a,     it.a.phase);
      chk("a_locked",    locked_a,    it.a.locked);
      chk("a_strobe",    strobe_a,    it.a.strobe);
      chk("a_lol_pulse", lol_pulse_a, it.a.pulse);
      chk("a_lol_count", lol_count_a, it.a.lol);
      chk("b_phase",     phase_b,     it.b.phase);
      chk("b_locked",    locked_b,    it.b.locked);
      chk("b_strobe",    strobe_b,    it.b.strobe);
      chk("b_lol_pulse", lol_pulse_b, it.b.pulse);
      chk("b_lol_count", lol_count_b, it.b.lol);
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    b_pos       = 0;
    reset_n     = 1'b0;
    lac_a       = 1'b0;
    lac_b       = 1'b0;
    lol_clear   = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    chk("rst_a_locked", locked_a, 0);
    chk("rst_a_phase",  phase_a,  0);
    chk("rst_a_strobe", strobe_a, 0);
    chk("rst_b_lol",    lol_count_b, 0);

    // Lock both instances.
    reset_n = 1'b1;
    a_normal(12);
    chk("lock4x_locked", locked_a, 1);
    chk("lock4x_lol",    lol_count_a, 0);
    chk("lock5x_locked", locked_b, 1);

    // Late edge: one stretched period.
    a_period(5, 2, -1, -1);
    a_normal(3);
    chk("late_unlocked", locked_a, 0);
    chk("late_lol",      lol_count_a, 1);
    a_normal(10);
    chk("late_relock",   locked_a, 1);

    // Glitch: extra rise at phase 1.
    a_period(4, 3, 1, -1);
    a_normal(3);
    chk("glitch_unlocked", locked_a, 0);
    chk("glitch_lol",      lol_count_a, 2);
    a_normal(10);

    // Losses 3..5: counter saturates at 3.
    for (int k = 0; k < 3; k++) begin
      a_period(5, 2, -1, -1);
      a_normal(10);
    end
    chk("sat_lol",    lol_count_a, 3);
    chk("sat_locked", locked_a, 1);

    // Sixth loss with lol_clear on the same edge: clear wins.
    a_period(5, 2, -1, -1);
    a_period(4, 2, -1, 0);
    a_normal(2);
    chk("clr_lol",    lol_count_a, 0);
    chk("clr_locked", locked_a, 0);
    a_normal(10);
    a_period(5, 2, -1, -1);
    a_normal(10);
    chk("prereset_lol",    lol_count_a, 1);
    chk("prereset_locked", locked_a, 1);

    // Asynchronous reset between clock edges.
    #2;
    sb_q.delete();
    reset_n = 1'b0;
    #1;
    chk("arst_a_locked", locked_a, 0);
    chk("arst_a_phase",  phase_a, 0);
    chk("arst_a_strobe", strobe_a, 0);
    chk("arst_a_pulse",  lol_pulse_a, 0);
    chk("arst_a_lol",    lol_count_a, 0);
    chk("arst_b_locked", locked_b, 0);
    chk("arst_b_phase",  phase_b, 0);
    model_reset();
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    a_normal(8);
    chk("relock_not_yet", locked_a, 0);
    a_normal(1);
    chk("relock_done",    locked_a, 1);
    a_normal(3);

    repeat (2) @(negedge clock);
    chk("sb_drain", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
